bp_be_npc_director: RTL
=======================

BP_BE_NPC_DIRECTOR -- requirements
Module: bp_be_npc_director

Interface
REQ-001 SHALL have parameter vaddr_width_p, default 39, virtual address width.
REQ-002 SHALL have parameter boot_pc_p, default 39'h00_8000_0000, expected-PC value at reset.
REQ-003 SHALL have parameter branch_pkt_width_lp (local), the bp_be_branch_pkt width for vaddr_width_p.
REQ-004 SHALL use one clock and an asynchronous, active-low reset.
REQ-005 clk_i  input  1  sole clock.
REQ-006 reset_n_i  input  1  asynchronous active-low reset.
REQ-007 br_pkt_i  input  branch_pkt_width_lp  resolved-instruction packet {v, branch, btaken, npc}.
REQ-008 isd_v_i  input  1  next instruction presented at issue.
REQ-009 isd_pc_i  input  vaddr_width_p  PC of that instruction.
REQ-010 redirect_v_i  input  1  exception/trap redirect request.
REQ-011 redirect_pc_i  input  vaddr_width_p  trap target PC.
REQ-012 fe_cmd_ready_i  input  1  frontend accepts redirect command.
REQ-013 fe_cmd_v_o  output  1  redirect command valid.
REQ-014 fe_cmd_pc_o  output  vaddr_width_p  redirect target PC.
REQ-015 poison_isd_o  output  1  kill instruction at issue this cycle.
REQ-016 npc_o  output  vaddr_width_p  current expected next PC.
REQ-017 mispredict_cnt_o  output  16  saturating mispredict count.

Function
REQ-018 npc_r SHALL load br_pkt_i.npc when br_pkt_i.v and state is RUN.
REQ-019 Expected PC for comparison SHALL be br_pkt_i.npc when br_pkt_i.v same cycle (bypass), else npc_r.
REQ-020 FSM SHALL have states RUN, CMD, WAIT.
REQ-021 RUN: isd_v_i with isd_pc_i != expected PC SHALL set poison_isd_o=1 combinationally, load npc_r with expected PC, go CMD, increment counter.
REQ-022 RUN: isd_v_i with matching PC SHALL pass (poison_isd_o=0), state unchanged.
REQ-023 CMD: fe_cmd_v_o=1, fe_cmd_pc_o=npc_r; transition to WAIT only on fe_cmd_v_o & fe_cmd_ready_i; fe_cmd_pc_o SHALL stay stable while not accepted.
REQ-024 CMD and WAIT: every isd_v_i SHALL be poisoned except in WAIT when isd_pc_i == npc_r, which passes and returns to RUN.
REQ-025 br_pkt_i.v outside RUN SHALL be ignored (protocol violation, flagged by assertion).
REQ-026 redirect_v_i SHALL take priority in any state: npc_r <= redirect_pc_i, state <= CMD, current isd poisoned, counter unchanged.
REQ-027 redirect_v_i during CMD handshake cycle SHALL override: stay CMD with new PC; the accepted old command is superseded.
REQ-028 Counter SHALL saturate at 16'hFFFF, never wrap.
REQ-029 npc_o SHALL equal npc_r; outputs fe_cmd_v_o, npc_o, mispredict_cnt_o registered; poison_isd_o combinational.
REQ-030 PC compares SHALL be full vaddr_width_p, bit 0 included.

Reset
REQ-031 On reset_n_i low, immediately: state RUN, npc_r = boot_pc_p, fe_cmd_v_o=0, counter=0.
REQ-032 Reset mid-CMD SHALL drop the pending command without handshake.
REQ-033 First isd_v_i after reset SHALL compare against boot_pc_p.

Structure
REQ-034 State enum (bp_be_director_state_e) SHALL live in bp_be_pkg; branch packet struct from existing bp_be internal-if macros.
REQ-035 No sub-module; counter and FSM inline.

Verification
REQ-036 Reset, isd_pc 39'h80000000 -> no poison, state RUN, count 0.
REQ-037 br_pkt {v=1,btaken=1,npc=0x80000100} with same-cycle isd_pc 0x80000004 -> poison=1, next cycle fe_cmd_v=1, pc 0x80000100, count 1.
REQ-038 CMD with fe_cmd_ready low 3 cycles then high -> fe_cmd_pc stable 4 cycles, WAIT next; isd 0x80000008 poisoned, isd 0x80000100 passes, RUN.
REQ-039 redirect_v with pc 0x80001000 during WAIT -> CMD, fe_cmd_pc 0x80001000, count unchanged.
REQ-040 Force 65536 mispredicts -> counter holds 0xFFFF.
REQ-041 Assert reset_n_i low mid-CMD asynchronously -> fe_cmd_v_o drops before next clock edge, npc_o = boot_pc_p.

Source files
------------

// File: rtl/bp_be_pkg.sv
// rtl/bp_be_pkg.sv - shared backend types for the next-PC director
package bp_be_pkg;

    typedef enum logic [1:0] {
        e_run  = 2'd0,
        e_cmd  = 2'd1,
        e_wait = 2'd2
    } bp_be_director_state_e;

    localparam int mispredict_cnt_width_gp = 16;

    // Branch packet is {v, branch, btaken, npc}
    function automatic int bp_be_branch_pkt_width(input int vaddr_width);
        return vaddr_width + 3;
    endfunction

endpackage

// File: rtl/bp_be_npc_director_if.sv
// rtl/bp_be_npc_director_if.sv - issue/redirect/frontend-command signal bundle
interface bp_be_npc_director_if #(
    parameter int vaddr_width_p = 39
) ();

    logic                     isd_v;
    logic [vaddr_width_p-1:0] isd_pc;
    logic                     redirect_v;
    logic [vaddr_width_p-1:0] redirect_pc;
    logic                     fe_cmd_ready;
    logic                     fe_cmd_v;
    logic [vaddr_width_p-1:0] fe_cmd_pc;
    logic                     poison_isd;

    modport master (
        input  isd_v, isd_pc, redirect_v, redirect_pc, fe_cmd_ready,
        output fe_cmd_v, fe_cmd_pc, poison_isd
    );

    modport slave (
        output isd_v, isd_pc, redirect_v, redirect_pc, fe_cmd_ready,
        input  fe_cmd_v, fe_cmd_pc, poison_isd
    );

endinterface

// File: rtl/bp_be_npc_director.sv
// rtl/bp_be_npc_director.sv - tracks expected next PC, poisons wrong-path issue, redirects frontend
module bp_be_npc_director
    import bp_be_pkg::*;
#(
    parameter int                     vaddr_width_p = 39,
    parameter logic [vaddr_width_p-1:0] boot_pc_p   = 39'h00_8000_0000,
    parameter logic [15:0]            cnt_max_p     = 16'hFFFF,
    localparam int                    branch_pkt_width_lp = bp_be_branch_pkt_width(vaddr_width_p)
) (
    input  logic                           clk_i,
    input  logic                           reset_n_i,

    input  logic [branch_pkt_width_lp-1:0] br_pkt_i,

    input  logic                           isd_v_i,
    input  logic [vaddr_width_p-1:0]       isd_pc_i,

    input  logic                           redirect_v_i,
    input  logic [vaddr_width_p-1:0]       redirect_pc_i,

    input  logic                           fe_cmd_ready_i,
    output logic                           fe_cmd_v_o,
    output logic [vaddr_width_p-1:0]       fe_cmd_pc_o,

    output logic                           poison_isd_o,
    output logic [vaddr_width_p-1:0]       npc_o,
    output logic [15:0]                    mispredict_cnt_o
);

    typedef struct packed {
        logic                     v;
        logic                     branch;
        logic                     btaken;
        logic [vaddr_width_p-1:0] npc;
    } bp_be_branch_pkt_s;

    bp_be_branch_pkt_s     br_pkt;
    bp_be_director_state_e state_q;
    logic [vaddr_width_p-1:0] npc_q;
    logic [vaddr_width_p-1:0] expected_pc;
    logic                  fe_cmd_v_q;
    logic [15:0]           cnt_q;
    logic [15:0]           cnt_d;
    logic                  mispredict;
    logic                  unused_br_info;

    assign br_pkt         = br_pkt_i;
    assign unused_br_info = br_pkt.branch ^ br_pkt.btaken;

    // A branch resolving this cycle is already the truth for the instruction at issue
    assign expected_pc = (state_q == e_run && br_pkt.v) ? br_pkt.npc : npc_q;

    assign mispredict = (state_q == e_run) && isd_v_i && !redirect_v_i
                        && (isd_pc_i != expected_pc);

    assign cnt_d = (cnt_q == cnt_max_p) ? cnt_q : cnt_q + 16'd1;

    always_comb begin
        poison_isd_o = 1'b0;
        if (redirect_v_i) begin
            poison_isd_o = isd_v_i;
        end else begin
            unique case (state_q)
                e_run:   poison_isd_o = isd_v_i && (isd_pc_i != expected_pc);
                e_cmd:   poison_isd_o = isd_v_i;
                e_wait:  poison_isd_o = isd_v_i && (isd_pc_i != npc_q);
                default: poison_isd_o = isd_v_i;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= e_run;
            npc_q      <= boot_pc_p;
            fe_cmd_v_q <= 1'b0;
            cnt_q      <= 16'd0;
        end else if (redirect_v_i) begin
            // Traps win everywhere, including over a command being accepted this cycle
            state_q    <= e_cmd;
            npc_q      <= redirect_pc_i;
            fe_cmd_v_q <= 1'b1;
        end else begin
            unique case (state_q)
                e_run: begin
                    if (br_pkt.v || mispredict) begin
                        npc_q <= expected_pc;
                    end
                    if (mispredict) begin
                        state_q    <= e_cmd;
                        fe_cmd_v_q <= 1'b1;
                        cnt_q      <= cnt_d;
                    end
                end
                e_cmd: begin
                    if (fe_cmd_ready_i) begin
                        state_q    <= e_wait;
                        fe_cmd_v_q <= 1'b0;
                    end
                end
                e_wait: begin
                    if (isd_v_i && isd_pc_i == npc_q) begin
                        state_q <= e_run;
                    end
                end
                default: begin
                    state_q    <= e_run;
                    fe_cmd_v_q <= 1'b0;
                end
            endcase
        end
    end

    assign fe_cmd_v_o       = fe_cmd_v_q;
    assign fe_cmd_pc_o      = npc_q;
    assign npc_o            = npc_q;
    assign mispredict_cnt_o = cnt_q;

    br_pkt_outside_run_a: assert property (
        @(posedge clk_i) disable iff (!reset_n_i) !(br_pkt.v && state_q != e_run)
    );

endmodule
